// File: rtl/utrap_pkg.sv
// Shared constants and FSM state type for the user-mode trap controller.
package utrap_pkg;

   // CSR indices as seen on oCSRAddr
   localparam logic [6:0] CSR_USTATUS = 7'd0;
   localparam logic [6:0] CSR_UIE     = 7'd4;
   localparam logic [6:0] CSR_UTVEC   = 7'd5;
   localparam logic [6:0] CSR_UEPC    = 7'd65;
   localparam logic [6:0] CSR_UCAUSE  = 7'd66;
   localparam logic [6:0] CSR_UTVAL   = 7'd67;
   localparam logic [6:0] CSR_UIP     = 7'd68;

   // Interrupt cause codes (bit 31 marks an interrupt)
   localparam logic [31:0] CAUSE_IRQ_EXT = 32'h8000_0008;
   localparam logic [31:0] CAUSE_IRQ_TMR = 32'h8000_0004;

   typedef enum logic [2:0] {
      IDLE,
      W_EPC,
      W_CAUSE,
      W_TVAL,
      W_STATUS,
      REDIR,
      R_STATUS,
      R_REDIR
   } utrap_state_t;

endpackage

// File: rtl/utrap_prio.sv
// Combinational request arbitration and cause selection.
module utrap_prio
   import utrap_pkg::*;
(
   input  logic        exc_req,
   input  logic [4:0]  exc_cause,
   input  logic        irq_ext,
   input  logic        irq_tmr,
   input  logic        instr_done,
   input  logic        uret,
   input  logic        glb_uie,
   input  logic        ueie,
   input  logic        utie,
   output logic        take_trap,
   output logic        take_uret,
   output logic        is_irq,
   output logic [31:0] cause
);

   logic ext_ok;
   logic tmr_ok;

   assign ext_ok = instr_done & irq_ext & glb_uie & ueie;
   assign tmr_ok = instr_done & irq_tmr & glb_uie & utie;

   // Fixed priority: exception > external > timer > uret
   always_comb begin
      take_trap = 1'b0;
      take_uret = 1'b0;
      is_irq    = 1'b0;
      cause     = 32'd0;
      if (exc_req) begin
         take_trap = 1'b1;
         cause     = {27'd0, exc_cause};
      end else if (ext_ok) begin
         take_trap = 1'b1;
         is_irq    = 1'b1;
         cause     = CAUSE_IRQ_EXT;
      end else if (tmr_ok) begin
         take_trap = 1'b1;
         is_irq    = 1'b1;
         cause     = CAUSE_IRQ_TMR;
      end else if (uret) begin
         take_uret = 1'b1;
      end
   end

endmodule

// File: rtl/utrap_controller.sv
// User-mode trap controller: sequences CSR writes and PC redirect for traps and uret.
module utrap_controller
   import utrap_pkg::*;
#(
   parameter bit UTVEC_MODE_EN = 1'b1
) (
   input  logic        iCLK,
   input  logic        iRSTn,
   input  logic        iEXC_Req,
   input  logic [4:0]  iEXC_Cause,
   input  logic [31:0] iEXC_PC,
   input  logic [31:0] iEXC_Tval,
   input  logic        iIRQ_Ext,
   input  logic        iIRQ_Tmr,
   input  logic        iInstrDone,
   input  logic [31:0] iNextPC,
   input  logic        iURET,
   input  logic [31:0] iUSTATUS,
   input  logic [31:0] iUIE,
   input  logic [31:0] iUTVEC,
   input  logic [31:0] iUEPC,
   output logic        oCSRWrite,
   output logic [6:0]  oCSRAddr,
   output logic [31:0] oCSRData,
   output logic        oStall,
   output logic        oPCRedirect,
   output logic [31:0] oPCTarget,
   output logic [31:0] oTrapCount
);

   utrap_state_t state_q, state_d;
   logic [31:0]  epc_q, cause_q, tval_q, count_q;
   logic         irq_q;

   logic         take_trap, take_uret, is_irq, accept;
   logic [31:0]  cause;
   logic [31:0]  tvec_base;
   logic         unused_uie;

   assign unused_uie = ^{iUIE[31:9], iUIE[7:5], iUIE[3:0]};

   utrap_prio u_prio (
      .exc_req    (iEXC_Req),
      .exc_cause  (iEXC_Cause),
      .irq_ext    (iIRQ_Ext),
      .irq_tmr    (iIRQ_Tmr),
      .instr_done (iInstrDone),
      .uret       (iURET),
      .glb_uie    (iUSTATUS[0]),
      .ueie       (iUIE[8]),
      .utie       (iUIE[4]),
      .take_trap  (take_trap),
      .take_uret  (take_uret),
      .is_irq     (is_irq),
      .cause      (cause)
   );

   assign accept    = (state_q == IDLE) & (take_trap | take_uret);
   assign tvec_base = {iUTVEC[31:2], 2'b00};

   // State register, trap capture and trap counter
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state_q <= IDLE;
         epc_q   <= 32'd0;
         cause_q <= 32'd0;
         tval_q  <= 32'd0;
         irq_q   <= 1'b0;
         count_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && take_trap) begin
            epc_q   <= is_irq ? iNextPC : iEXC_PC;
            tval_q  <= is_irq ? 32'd0 : iEXC_Tval;
            cause_q <= cause;
            irq_q   <= is_irq;
         end
         if (state_q == REDIR) begin
            count_q <= count_q + 32'd1;
         end
      end
   end

   // Next-state: requests only looked at in IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (take_trap)      state_d = W_EPC;
            else if (take_uret) state_d = R_STATUS;
         end
         W_EPC:    state_d = W_CAUSE;
         W_CAUSE:  state_d = W_TVAL;
         W_TVAL:   state_d = W_STATUS;
         W_STATUS: state_d = REDIR;
         REDIR:    state_d = IDLE;
         R_STATUS: state_d = R_REDIR;
         R_REDIR:  state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Outputs decoded from state; all zero when idle
   always_comb begin
      oCSRWrite   = 1'b0;
      oCSRAddr    = 7'd0;
      oCSRData    = 32'd0;
      oPCRedirect = 1'b0;
      oPCTarget   = 32'd0;
      unique case (state_q)
         W_EPC: begin
            oCSRWrite = 1'b1;
            oCSRAddr  = CSR_UEPC;
            oCSRData  = epc_q;
         end
         W_CAUSE: begin
            oCSRWrite = 1'b1;
            oCSRAddr  = CSR_UCAUSE;
            oCSRData  = cause_q;
         end
         W_TVAL: begin
            oCSRWrite = 1'b1;
            oCSRAddr  = CSR_UTVAL;
            oCSRData  = tval_q;
         end
         W_STATUS: begin
            // UPIE <= UIE, UIE <= 0
            oCSRWrite = 1'b1;
            oCSRAddr  = CSR_USTATUS;
            oCSRData  = {iUSTATUS[31:5], iUSTATUS[0], iUSTATUS[3:1], 1'b0};
         end
         REDIR: begin
            oPCRedirect = 1'b1;
            if (UTVEC_MODE_EN && iUTVEC[1:0] == 2'b01 && irq_q) begin
               oPCTarget = tvec_base + {25'd0, cause_q[4:0], 2'b00};
            end else begin
               oPCTarget = tvec_base;
            end
         end
         R_STATUS: begin
            // UIE <= UPIE, UPIE <= 1
            oCSRWrite = 1'b1;
            oCSRAddr  = CSR_USTATUS;
            oCSRData  = {iUSTATUS[31:5], 1'b1, iUSTATUS[3:1], iUSTATUS[4]};
         end
         R_REDIR: begin
            oPCRedirect = 1'b1;
            oPCTarget   = iUEPC;
         end
         default: ;
      endcase
   end

   // Stall is combinational in the accepting cycle; forced low while in reset
   assign oStall     = iRSTn & ((state_q != IDLE) | accept);
   assign oTrapCount = count_q;

endmodule

// File: tb/tb_utrap_controller.sv
// Randomised self-checking bench for utrap_controller against a transaction-level model.
module tb_utrap_controller;

   logic        iCLK = 1'b0;
   logic        iRSTn;
   logic        iEXC_Req;
   logic [4:0]  iEXC_Cause;
   logic [31:0] iEXC_PC, iEXC_Tval;
   logic        iIRQ_Ext, iIRQ_Tmr, iInstrDone;
   logic [31:0] iNextPC;
   logic        iURET;
   logic [31:0] iUSTATUS, iUIE, iUTVEC, iUEPC;
   logic        oCSRWrite;
   logic [6:0]  oCSRAddr;
   logic [31:0] oCSRData;
   logic        oStall, oPCRedirect;
   logic [31:0] oPCTarget, oTrapCount;

   int total = 0;
   int bad   = 0;

   // Expected per-cycle bus activity after an accepted request
   typedef struct {
      logic        we;
      logic [6:0]  addr;
      logic [31:0] data;
      logic        redir;
      logic [31:0] target;
      logic        counts;
   } step_t;

   step_t       q[$];
   logic [31:0] cnt;

   utrap_controller #(.UTVEC_MODE_EN(1'b1)) dut (
      .iCLK        (iCLK),
      .iRSTn       (iRSTn),
      .iEXC_Req    (iEXC_Req),
      .iEXC_Cause  (iEXC_Cause),
      .iEXC_PC     (iEXC_PC),
      .iEXC_Tval   (iEXC_Tval),
      .iIRQ_Ext    (iIRQ_Ext),
      .iIRQ_Tmr    (iIRQ_Tmr),
      .iInstrDone  (iInstrDone),
      .iNextPC     (iNextPC),
      .iURET       (iURET),
      .iUSTATUS    (iUSTATUS),
      .iUIE        (iUIE),
      .iUTVEC      (iUTVEC),
      .iUEPC       (iUEPC),
      .oCSRWrite   (oCSRWrite),
      .oCSRAddr    (oCSRAddr),
      .oCSRData    (oCSRData),
      .oStall      (oStall),
      .oPCRedirect (oPCRedirect),
      .oPCTarget   (oPCTarget),
      .oTrapCount  (oTrapCount)
   );

   always #5 iCLK = ~iCLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic step_t mk(input logic we, input logic [6:0] addr, input logic [31:0] data,
                                input logic redir, input logic [31:0] target, input logic counts);
      step_t s;
      s.we = we; s.addr = addr; s.data = data;
      s.redir = redir; s.target = target; s.counts = counts;
      return s;
   endfunction

   // Decide what (if anything) the controller accepts this idle cycle; queue the expected bus steps
   function automatic bit model_accept();
      bit          irq;
      logic [31:0] c, epc, tval, us_new, tgt, base;
      bit          ie = iUSTATUS[0];
      if (iEXC_Req) begin
         irq = 0; c = 32'(iEXC_Cause); epc = iEXC_PC; tval = iEXC_Tval;
      end else if (iInstrDone && iIRQ_Ext && ie && iUIE[8]) begin
         irq = 1; c = 32'h8000_0008; epc = iNextPC; tval = 0;
      end else if (iInstrDone && iIRQ_Tmr && ie && iUIE[4]) begin
         irq = 1; c = 32'h8000_0004; epc = iNextPC; tval = 0;
      end else if (iURET) begin
         us_new = (iUSTATUS & ~32'h11) | 32'h10 | ((iUSTATUS >> 4) & 32'h1);
         q.push_back(mk(1, 7'd0, us_new, 0, 0, 0));
         q.push_back(mk(0, 7'd0, 0, 1, iUEPC, 0));
         return 1;
      end else begin
         return 0;
      end
      base   = iUTVEC & ~32'h3;
      tgt    = (irq && (iUTVEC & 32'h3) == 32'h1) ? base + (c % 32) * 4 : base;
      us_new = (iUSTATUS & ~32'h11) | ((iUSTATUS & 32'h1) << 4);
      q.push_back(mk(1, 7'd65, epc, 0, 0, 0));
      q.push_back(mk(1, 7'd66, c, 0, 0, 0));
      q.push_back(mk(1, 7'd67, tval, 0, 0, 0));
      q.push_back(mk(1, 7'd0, us_new, 0, 0, 0));
      q.push_back(mk(0, 7'd0, 0, 1, tgt, 1));
      return 1;
   endfunction

   // Inputs already driven; check this cycle, then advance to the next falling edge
   task automatic run_cycle();
      step_t e;
      bit    acc;
      bit    bump = 0;
      #1;
      if (q.size() == 0) begin
         acc = model_accept();
         e   = mk(0, 7'd0, 0, 0, 0, 0);
         check_val("stall_idle", 32'(oStall), 32'(acc));
      end else begin
         e = q.pop_front();
         check_val("stall_busy", 32'(oStall), 32'd1);
         bump = e.counts;
      end
      check_val("csr_we", 32'(oCSRWrite), 32'(e.we));
      check_val("csr_addr", 32'(oCSRAddr), 32'(e.addr));
      check_val("csr_data", oCSRData, e.data);
      check_val("redir", 32'(oPCRedirect), 32'(e.redir));
      check_val("target", oPCTarget, e.target);
      check_val("trap_count", oTrapCount, cnt);
      @(posedge iCLK);
      if (bump) cnt = cnt + 1;
      @(negedge iCLK);
   endtask

   task automatic clear_reqs();
      iEXC_Req = 0; iIRQ_Ext = 0; iIRQ_Tmr = 0; iInstrDone = 0; iURET = 0;
   endtask

   task automatic drain();
      clear_reqs();
      for (int i = 0; i < 20 && q.size() != 0; i++) run_cycle();
      check_val("drained", 32'(q.size()), 32'd0);
   endtask

   initial begin
      iRSTn = 0; cnt = 0;
      clear_reqs();
      iEXC_Cause = 0; iEXC_PC = 0; iEXC_Tval = 0; iNextPC = 0;
      iUSTATUS = 0; iUIE = 0; iUTVEC = 0; iUEPC = 0;
      repeat (2) @(negedge iCLK);
      check_val("rst_we", 32'(oCSRWrite), 0);
      check_val("rst_stall", 32'(oStall), 0);
      check_val("rst_count", oTrapCount, 0);
      iRSTn = 1;
      @(negedge iCLK);

      // Exception, direct vector
      iEXC_Req = 1; iEXC_Cause = 5'd2; iEXC_PC = 32'h400; iEXC_Tval = 32'hDEAD;
      iUTVEC = 32'h100; iUSTATUS = 32'h1; iUIE = 0;
      run_cycle();
      drain();

      // External interrupt, vectored
      iIRQ_Ext = 1; iInstrDone = 1; iUSTATUS = 32'h1; iUIE = 32'h100;
      iNextPC = 32'h208; iUTVEC = 32'h101;
      run_cycle();
      drain();

      // Timer with global UIE clear: ignored
      iIRQ_Tmr = 1; iInstrDone = 1; iUSTATUS = 32'h0; iUIE = 32'h10;
      run_cycle();
      run_cycle();
      drain();

      // Everything at once: exception wins, requests held high mid-sequence are ignored
      iEXC_Req = 1; iEXC_Cause = 5'd7; iEXC_PC = 32'h800; iEXC_Tval = 32'h55;
      iIRQ_Ext = 1; iInstrDone = 1; iURET = 1; iUSTATUS = 32'h1; iUIE = 32'h110;
      iUTVEC = 32'h201;
      for (int i = 0; i < 6; i++) run_cycle();
      drain();

      // uret
      iURET = 1; iUSTATUS = 32'h10; iUEPC = 32'h404;
      run_cycle();
      drain();

      // Reset in W_CAUSE
      iEXC_Req = 1; iEXC_Cause = 5'd3; iEXC_PC = 32'hC00; iEXC_Tval = 32'h1;
      run_cycle();
      run_cycle();
      iRSTn = 0;
      #1;
      check_val("arst_we", 32'(oCSRWrite), 0);
      check_val("arst_data", oCSRData, 0);
      check_val("arst_stall", 32'(oStall), 0);
      check_val("arst_count", oTrapCount, 0);
      q.delete();
      cnt = 0;
      @(negedge iCLK);
      iRSTn = 1;
      iEXC_Cause = 5'd11; iEXC_PC = 32'h1234; iUTVEC = 32'h300;
      run_cycle();
      drain();

      // Randomised traffic; CSR view inputs only change while the model is idle
      for (int n = 0; n < 600; n++) begin
         if (q.size() == 0) begin
            iUSTATUS = $urandom() & 32'hFFFF_FF11;
            iUIE     = ($urandom_range(0, 1) ? 32'h100 : 0) | ($urandom_range(0, 1) ? 32'h10 : 0);
            iUTVEC   = $urandom();
            iUEPC    = $urandom();
         end
         iEXC_Req   = ($urandom_range(0, 9) == 0);
         iEXC_Cause = 5'($urandom());
         iEXC_PC    = $urandom();
         iEXC_Tval  = $urandom();
         iIRQ_Ext   = ($urandom_range(0, 3) == 0);
         iIRQ_Tmr   = ($urandom_range(0, 3) == 0);
         iInstrDone = $urandom_range(0, 1);
         iNextPC    = $urandom();
         iURET      = ($urandom_range(0, 7) == 0);
         run_cycle();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/utrap_controller.md
UTRAP_CONTROLLER -- requirements
Module: utrap_controller

Interface
REQ-001 SHALL have parameter UTVEC_MODE_EN, default 1; 1 enables vectored utvec mode, 0 forces direct mode.
REQ-002 SHALL have ports:
- iCLK  in  1  sole clock, rising edge.
- iRSTn  in  1  asynchronous, active-low reset.
- iEXC_Req  in  1  synchronous exception pending for the current instruction.
- iEXC_Cause  in  5  exception code.
- iEXC_PC  in  32  PC of the faulting instruction.
- iEXC_Tval  in  32  trap value.
- iIRQ_Ext  in  1  user external interrupt line, level.
- iIRQ_Tmr  in  1  user timer interrupt line, level.
- iInstrDone  in  1  instruction-boundary pulse.
- iNextPC  in  32  PC of the next instruction.
- iURET  in  1  uret is executing.
- iUSTATUS  in  32  current ustatus.
- iUIE  in  32  current uie.
- iUTVEC  in  32  current utvec.
- iUEPC  in  32  current uepc.
- oCSRWrite  out  1  CSR write strobe.
- oCSRAddr  out  7  CSR index.
- oCSRData  out  32  CSR write data.
- oStall  out  1  holds the datapath.
- oPCRedirect  out  1  one-cycle PC load.
- oPCTarget  out  32  redirect target.
- oTrapCount  out  32  number of traps taken.

Function
REQ-003 SHALL use FSM states IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIR, R_STATUS, R_REDIR.
REQ-004 SHALL evaluate requests only in IDLE; all request inputs SHALL be ignored in every other state.
REQ-005 SHALL apply IDLE priority: iEXC_Req > external interrupt > timer interrupt > iURET.
REQ-006 SHALL take an external interrupt only when iInstrDone=1, iIRQ_Ext=1, iUSTATUS[0]=1 and iUIE[8]=1.
REQ-007 SHALL take a timer interrupt only when iInstrDone=1, iIRQ_Tmr=1, iUSTATUS[0]=1 and iUIE[4]=1.
REQ-008 SHALL compute the registered cause on acceptance:
- exception: {27'b0, iEXC_Cause}.
- external: 32'h8000_0008.
- timer: 32'h8000_0004.
REQ-009 SHALL capture epc on acceptance: iEXC_PC for exceptions, iNextPC for interrupts.
REQ-010 SHALL capture tval on acceptance: iEXC_Tval for exceptions, 0 for interrupts.
REQ-011 SHALL, on acceptance at edge T, step through W_EPC, W_CAUSE, W_TVAL, W_STATUS in cycles T+1..T+4, one oCSRWrite per cycle, to CSR indices 65, 66, 67, 0.
REQ-012 SHALL write ustatus in W_STATUS as iUSTATUS with bit4 (UPIE) set to the old bit0 and bit0 (UIE) cleared.
REQ-013 SHALL pulse oPCRedirect in REDIR (cycle T+5), then return to IDLE.
REQ-014 SHALL compute oPCTarget in REDIR:
- if UTVEC_MODE_EN=1, iUTVEC[1:0]=01 and the trap is an interrupt: {iUTVEC[31:2],2'b00} + 4*cause[4:0].
- otherwise: {iUTVEC[31:2],2'b00}.
REQ-015 SHALL, on iURET accepted in IDLE, go R_STATUS then R_REDIR; R_STATUS writes CSR 0 with UIE = old UPIE and UPIE = 1; R_REDIR pulses oPCRedirect with oPCTarget = iUEPC.
REQ-016 SHALL assert oStall in every non-IDLE state and in the IDLE cycle in which a request is accepted (combinational in that cycle).
REQ-017 SHALL drive oCSRWrite, oCSRAddr, oCSRData and oPCTarget to 0 whenever no write or redirect is occurring.
REQ-018 SHALL increment oTrapCount by 1 on each REDIR cycle, wrapping 32'hFFFF_FFFF to 0; uret SHALL NOT count.
REQ-019 SHALL never nest traps: after W_STATUS, UIE=0 blocks interrupts; an exception is still accepted, since interrupt enables do not gate exceptions.

Reset
REQ-020 SHALL, when iRSTn=0 at any time, including mid-sequence, enter IDLE immediately and zero all outputs, oTrapCount and captured registers.
REQ-021 SHALL NOT roll back CSR writes already issued before reset.
REQ-022 SHALL resume normal operation on the first rising iCLK after iRSTn deasserts.

Structure
REQ-023 SHALL place in shared package utrap_pkg: CSR index constants (USTATUS=0, UIE=4, UTVEC=5, UEPC=65, UCAUSE=66, UTVAL=67, UIP=68), cause constants, and the FSM state enumeration.
REQ-024 SHALL implement priority and cause selection in sub-module utrap_prio, which is purely combinational.

Verification
REQ-025 SHALL cover: iEXC_Req=1, cause=2, PC=0x400, tval=0xDEAD, iUTVEC=0x100 -> writes 65=0x400, 66=0x2, 67=0xDEAD, 0=UPIE/UIE updated; oPCTarget=0x100 at T+5; oTrapCount=1.
REQ-026 SHALL cover: iIRQ_Ext=1, iUSTATUS=1, iUIE=0x100, iInstrDone=1, iNextPC=0x208, iUTVEC=0x101 -> uepc=0x208, ucause=0x80000008, target=0x120.
REQ-027 SHALL cover: iIRQ_Tmr=1 with iUSTATUS[0]=0 -> no write, oStall=0, state remains IDLE.
REQ-028 SHALL cover: iEXC_Req, iIRQ_Ext and iURET all high in the same cycle -> exception sequence only; new requests ignored during the sequence.
REQ-029 SHALL cover: uret with iUSTATUS=0x10, iUEPC=0x404 -> ustatus write 0x11, redirect to 0x404, oTrapCount unchanged.
REQ-030 SHALL cover: iRSTn pulled low in W_CAUSE -> outputs 0 asynchronously; IDLE after release; a fresh request is handled normally.
